// File: rtl/psum_acc_pkg.sv
// -----------------------------------------------------------------------------
// psum_acc_pkg
// Shared definitions for the psum accumulation sequencer.
//   state_t  : sequencer states (IDLE, READ, WAIT, WRITE, FIN)
//   lane_lo  : LSB position of a column lane inside a packed vector
// -----------------------------------------------------------------------------
package psum_acc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        FIN   = 3'd4
    } state_t;

    // Lane i occupies bits [width*(i+1)-1 : width*i] of a packed vector.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/psum_acc_lane.sv
// -----------------------------------------------------------------------------
// acc_lane
// One signed accumulator lane. Loads on the first beat of a pixel and adds on
// later beats (two's complement, wraps modulo 2^BW). On capture the final sum,
// optionally passed through ReLU, is registered as the lane's write data.
// Optional feature: define SFP_RELU_EN to clamp negative results to zero.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   beat       : psum_in carries a valid beat this cycle
//   first      : this beat is kij=0 (load instead of add)
//   capture    : register the final (post-ReLU) value into res
//   psum_in    : lane slice of the psum read data
//   res        : registered lane result for the output SRAM
// -----------------------------------------------------------------------------
module acc_lane #(
    parameter int BW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          beat,
    input  logic          first,
    input  logic          capture,
    input  logic [BW-1:0] psum_in,
    output logic [BW-1:0] res
);

    logic [BW-1:0] acc_reg;
    logic [BW-1:0] acc_next;
    logic [BW-1:0] res_val;
    logic [BW-1:0] res_reg;

    // Modular addition is identical for signed and unsigned operands; the sign
    // only matters for the ReLU decision below.
    always_comb begin
        acc_next = first ? psum_in : (acc_reg + psum_in);
    end

    // Capture coincides with the last beat, so the result is taken from
    // acc_next rather than the not-yet-updated acc_reg.
    always_comb begin
`ifdef SFP_RELU_EN
        res_val = acc_next[BW-1] ? '0 : acc_next;
`else
        res_val = acc_next;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg <= '0;
            res_reg <= '0;
        end else begin
            if (beat)    acc_reg <= acc_next;
            if (capture) res_reg <= res_val;
        end
    end

    assign res = res_reg;

endmodule

// File: rtl/psum_acc_seq.sv
// -----------------------------------------------------------------------------
// psum_acc_seq
// Drains partial sums from the psum SRAM, accumulates NUM_KIJ kernel positions
// per output pixel, optionally applies ReLU, and writes one vector per pixel
// to the output SRAM.
// Optional feature: define SFP_RELU_EN to enable ReLU on every lane.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : run request, sampled only in IDLE
//   busy       : high from the cycle after start until done
//   done       : one-cycle pulse in FIN
//   psum_cen   : psum SRAM chip enable (active-low), low only in READ
//   psum_addr  : psum read address = kij*NUM_OUT + o
//   psum_q     : psum read data, valid one cycle after psum_cen low
//   out_wen    : output SRAM write enable (active-low), low only in WRITE
//   out_addr   : output write address (= o)
//   out_d      : output write data, lane i = bits [bw*(i+1)-1 : bw*i]
// -----------------------------------------------------------------------------
module psum_acc_seq
    import psum_acc_pkg::*;
#(
    parameter int bw      = 16,
    parameter int col     = 8,
    parameter int NUM_KIJ = 9,
    parameter int NUM_OUT = 16,
    parameter int PSUM_AW = 8,
    parameter int OUT_AW  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                psum_cen,
    output logic [PSUM_AW-1:0]  psum_addr,
    input  logic [bw*col-1:0]   psum_q,
    output logic                out_wen,
    output logic [OUT_AW-1:0]   out_addr,
    output logic [bw*col-1:0]   out_d
);

    localparam int KW = (NUM_KIJ > 1) ? $clog2(NUM_KIJ) : 1;

    state_t             state_reg, state_next;
    logic [KW-1:0]      kij_reg;
    logic [OUT_AW-1:0]  o_reg;
    logic [PSUM_AW-1:0] addr_reg;
    logic               beat_reg;      // psum_q carries a beat this cycle
    logic               first_reg;     // that beat is kij=0
    logic               out_wen_reg;
    logic [OUT_AW-1:0]  out_addr_reg;
    logic               last_kij;
    logic               last_out;
    logic               capture;

    assign last_kij = (kij_reg == KW'(NUM_KIJ - 1));
    assign last_out = (o_reg == OUT_AW'(NUM_OUT - 1));
    // Write data is registered at the edge leaving WAIT so it is presented
    // during the WRITE cycle together with out_wen.
    assign capture  = (state_reg == WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        psum_cen   = 1'b1;
        case (state_reg)
            IDLE: begin
                if (start) state_next = READ;
            end
            READ: begin
                busy     = 1'b1;
                psum_cen = 1'b0;
                if (last_kij) state_next = WAIT;
            end
            WAIT: begin
                busy       = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                busy       = 1'b1;
                state_next = last_out ? FIN : READ;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters and address generation. The address advances by NUM_OUT per
    // kernel position and is rebased to the next pixel in WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kij_reg      <= '0;
            o_reg        <= '0;
            addr_reg     <= '0;
            beat_reg     <= 1'b0;
            first_reg    <= 1'b0;
            out_wen_reg  <= 1'b1;
            out_addr_reg <= '0;
        end else begin
            beat_reg    <= (state_reg == READ);
            first_reg   <= (state_reg == READ) && (kij_reg == '0);
            out_wen_reg <= !capture;
            if (capture) out_addr_reg <= o_reg;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        kij_reg  <= '0;
                        o_reg    <= '0;
                        addr_reg <= '0;
                    end
                end
                READ: begin
                    if (last_kij) begin
                        kij_reg <= '0;
                    end else begin
                        kij_reg  <= kij_reg + KW'(1);
                        addr_reg <= addr_reg + PSUM_AW'(NUM_OUT);
                    end
                end
                WRITE: begin
                    if (!last_out) begin
                        o_reg    <= o_reg + OUT_AW'(1);
                        addr_reg <= PSUM_AW'(o_reg) + PSUM_AW'(1);
                    end
                end
                FIN: begin
                    o_reg    <= '0;
                    addr_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    assign psum_addr = addr_reg;
    assign out_wen   = out_wen_reg;
    assign out_addr  = out_addr_reg;

    for (genvar gi = 0; gi < col; gi++) begin : g_lane
        localparam int LO = lane_lo(gi, bw);
        acc_lane #(.BW(bw)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .beat    (beat_reg),
            .first   (first_reg),
            .capture (capture),
            .psum_in (psum_q[LO +: bw]),
            .res     (out_d[LO +: bw])
        );
    end

endmodule
